// File: rtl/tick_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tick_sched_pkg
// Brief   : Shared state encoding, defaults and width helper for tick_scheduler
// Revision: 1.0 - initial release
// ============================================================================
package tick_sched_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    // Prescaler terminal count for the board-level periodic tick.
    localparam int DEFAULT_DIV_MAX = 70000;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tick_prescaler
// Brief   : Wrapping divide counter producing a registered one-cycle tick
// Revision: 1.0 - initial release
// ============================================================================
module tick_prescaler
    import tick_sched_pkg::*;
#(
    parameter int DIV_MAX = DEFAULT_DIV_MAX,
    parameter int CNT_W   = clog2(DIV_MAX + 1)
) (
    input  logic clk_50mhz,
    input  logic rst_50mhz,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIV_MAX);

    logic [CNT_W-1:0] div_cnt;

    // Disabling parks the counter at zero so re-enable gives a full period.
    always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
        if (rst_50mhz) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == TERMINAL);
            div_cnt <= (div_cnt == TERMINAL) ? '0 : div_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tick_scheduler
// Brief   : Round-robin time-slot scheduler granting one requester per tick
// Revision: 1.0 - initial release
// ============================================================================
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int DIV_MAX       = DEFAULT_DIV_MAX,
    parameter int N_REQ         = 4,
    parameter int TIMEOUT_TICKS = 8,
    localparam int ID_W         = clog2(N_REQ)
) (
    input  logic             clk_50mhz,
    input  logic             rst_50mhz,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             tick,
    output logic             busy,
    output logic             timeout_err
);

    localparam int              TO_W    = clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);

    logic [1:0]      state;
    logic [ID_W-1:0] last_id;
    logic [TO_W-1:0] to_cnt;
    logic [ID_W-1:0] sel_id;
    logic [ID_W-1:0] cand;
    logic            sel_valid;

    tick_prescaler #(
        .DIV_MAX (DIV_MAX)
    ) u_prescaler (
        .clk_50mhz (clk_50mhz),
        .rst_50mhz (rst_50mhz),
        .enable    (enable),
        .tick      (tick)
    );

    // Round-robin search starting one past the previous winner.
    always_comb begin
        sel_id    = '0;
        sel_valid = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((int'(last_id) + i) % N_REQ);
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_id    = cand;
            end
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
        if (rst_50mhz) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            last_id     <= ID_LAST;
            busy        <= 1'b0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (!enable) begin
                state <= (state == GRANT) ? RELEASE : IDLE;
                grant <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tick && sel_valid) begin
                            state    <= GRANT;
                            grant    <= N_REQ'(1) << sel_id;
                            grant_id <= sel_id;
                            last_id  <= sel_id;
                            busy     <= 1'b1;
                            to_cnt   <= '0;
                        end
                    end
                    GRANT: begin
                        // Completion outranks the timeout when both land together.
                        if (done[grant_id] || !req[grant_id]) begin
                            state <= RELEASE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end else if (tick && (to_cnt == TO_LAST)) begin
                            state       <= RELEASE;
                            grant       <= '0;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                        end else if (tick) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    RELEASE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_tick_scheduler
// Brief   : Directed plus randomized bench for tick_scheduler against a slot model
// Revision: 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int PERIOD  = 10;
    localparam int TIMEOUT = 3;

    logic       clk_50mhz = 1'b0;
    logic       rst_50mhz;
    logic       enable;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       tick;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the slot, how many ticks it has seen, and
    // whether we are in the one-cycle gap after a release.
    int m_run, m_holder, m_last, m_gid, m_ticks;
    bit m_cool, m_tick, m_terr;

    logic [3:0] prev_grant;
    logic       prev_tick;
    bit         rise;
    logic [1:0] rise_id;

    tick_scheduler #(
        .DIV_MAX       (PERIOD - 1),
        .N_REQ         (4),
        .TIMEOUT_TICKS (TIMEOUT)
    ) dut (
        .clk_50mhz   (clk_50mhz),
        .rst_50mhz   (rst_50mhz),
        .enable      (enable),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .tick        (tick),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run    = 0;
        m_holder = -1;
        m_last   = 3;
        m_gid    = 0;
        m_ticks  = 0;
        m_cool   = 1'b0;
        m_tick   = 1'b0;
        m_terr   = 1'b0;
    endtask

    task automatic model_step();
        bit old_tick;
        if (rst_50mhz) begin
            model_reset();
            return;
        end
        old_tick = m_tick;
        m_terr   = 1'b0;
        if (enable) begin
            m_run++;
            m_tick = ((m_run % PERIOD) == 0);
        end else begin
            m_run  = 0;
            m_tick = 1'b0;
        end
        if (!enable) begin
            m_cool   = (m_holder >= 0);
            m_holder = -1;
        end else if (m_holder >= 0) begin
            if (done[m_holder[1:0]] || !req[m_holder[1:0]]) begin
                m_holder = -1;
                m_cool   = 1'b1;
            end else if (old_tick) begin
                m_ticks++;
                if (m_ticks == TIMEOUT) begin
                    m_holder = -1;
                    m_cool   = 1'b1;
                    m_terr   = 1'b1;
                end
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (old_tick && req != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (req[c[1:0]]) begin
                    m_holder = c;
                    break;
                end
            end
            m_last  = m_holder;
            m_gid   = m_holder;
            m_ticks = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk_50mhz);
        model_step();
        #1;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("grant", 32'(grant), (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0);
        chk("busy", 32'(busy), 32'(m_holder >= 0));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        rise    = (grant != 4'b0) && (prev_grant == 4'b0);
        rise_id = grant_id;
        if (rise) chk("grant_after_tick", 32'(prev_tick), 32'd1);
        prev_grant = grant;
        prev_tick  = tick;
        done       = 4'b0;
    endtask

    initial begin
        int ntick, dly, nt, nterr, n;
        bit seen, ok;
        int q[$];

        rst_50mhz  = 1'b1;
        enable     = 1'b0;
        req        = 4'b0;
        done       = 4'b0;
        prev_grant = 4'b0;
        prev_tick  = 1'b0;
        model_reset();
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        cyc();
        cyc();
        rst_50mhz = 1'b0;
        enable    = 1'b1;

        // Idle ticking with no requests
        ntick = 0;
        repeat (40) begin
            cyc();
            if (tick) ntick++;
        end
        chk("t1_tick_count", 32'(ntick), 32'd4);

        // Two requesters alternating, done three clocks after each grant
        req = 4'b0101;
        dly = 0;
        for (int c = 0; c < 300; c++) begin
            cyc();
            if (dly > 0) begin
                dly--;
                if (dly == 0) done = prev_grant;
            end
            if (rise) begin
                q.push_back(int'(rise_id));
                dly = 3;
            end
            if (q.size() == 4 && dly == 0 && grant == 4'b0) break;
        end
        chk("t2_grant_count", 32'(q.size()), 32'd4);
        if (q.size() == 4) begin
            chk("t2_id0", 32'(q[0]), 32'd0);
            chk("t2_id1", 32'(q[1]), 32'd2);
            chk("t2_id2", 32'(q[2]), 32'd0);
            chk("t2_id3", 32'(q[3]), 32'd2);
        end
        req = 4'b0;
        repeat (3) cyc();

        // Requester 3 never completes: forced release, then re-grant
        req   = 4'b1000;
        nt    = 0;
        nterr = 0;
        seen  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            cyc();
            if (timeout_err) nterr++;
            if (rise && nterr > 0) begin
                seen = 1'b1;
                chk("t3_regrant_id", 32'(rise_id), 32'd3);
                break;
            end
            if (grant == 4'b1000 && tick) nt++;
        end
        chk("t3_regrant_seen", 32'(seen), 32'd1);
        chk("t3_ticks_held", 32'(nt), 32'(TIMEOUT));
        chk("t3_timeout_pulses", 32'(nterr), 32'd1);
        req = 4'b0;
        repeat (3) cyc();

        // done lands on the same edge as the final timeout tick
        req   = 4'b0010;
        nt    = 0;
        nterr = 0;
        ok    = 1'b0;
        for (int c = 0; c < 200; c++) begin
            cyc();
            if (timeout_err) nterr++;
            if (ok && grant == 4'b0) break;
            if (grant == 4'b0010 && tick) begin
                nt++;
                if (nt == TIMEOUT) begin
                    done = 4'b0010;
                    ok   = 1'b1;
                end
            end
        end
        chk("t4_released", 32'(grant), 32'd0);
        chk("t4_no_timeout", 32'(nterr), 32'd0);
        repeat (2) cyc();

        // Disable while requester 1 is granted, then re-enable
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (grant == 4'b0010) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_granted", 32'(seen), 32'd1);
        enable = 1'b0;
        cyc();
        chk("t5_grant_dropped", 32'(grant), 32'd0);
        ntick = 0;
        repeat (25) begin
            cyc();
            if (tick) ntick++;
            chk("t5_div_cnt", 32'(dut.u_prescaler.div_cnt), 32'd0);
        end
        chk("t5_no_ticks", 32'(ntick), 32'd0);
        enable = 1'b1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            n++;
            if (tick) break;
        end
        chk("t5_first_tick_latency", 32'(n), 32'(PERIOD));

        // Asynchronous reset mid-grant
        seen = (grant != 4'b0);
        for (int c = 0; c < 40 && !seen; c++) begin
            cyc();
            seen = (grant != 4'b0);
        end
        chk("t6_granted", 32'(seen), 32'd1);
        #2;
        rst_50mhz = 1'b1;
        #1;
        chk("t6_async_grant", 32'(grant), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_terr", 32'(timeout_err), 32'd0);
        model_reset();
        cyc();
        cyc();
        rst_50mhz = 1'b0;
        req       = 4'b1111;
        seen      = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (rise) begin
                seen = 1'b1;
                chk("t6_first_id", 32'(rise_id), 32'd0);
                break;
            end
        end
        chk("t6_regrant_seen", 32'(seen), 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) req = 4'($urandom);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            if ($urandom_range(0, 5) == 0) done = 4'b1 << $urandom_range(0, 3);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
